// File: rtl/tdm_demux_if.sv
// rtl/tdm_demux_if.sv - serial TDM receive bundle: bit strobe, data, sync marker and parallel frame outputs
interface tdm_demux_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  logic                        en;
  logic                        din;
  logic                        sync;
  logic [CHANNELS*WIDTH-1:0]   ch_data;
  logic                        frame_valid;
  logic                        sync_err;
  logic                        parity_err;

  modport master (
    output en, din, sync,
    input  ch_data, frame_valid, sync_err, parity_err
  );

  modport slave (
    input  en, din, sync,
    output ch_data, frame_valid, sync_err, parity_err
  );
endinterface

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - 1-bit TDM link receiver: sync alignment, per-channel deserialise, parallel frame out (optional trailing even parity with TDM_PARITY_EN)
module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux_if.slave    bus
);
  localparam int N  = CHANNELS * WIDTH;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(CHANNELS);
  localparam int BW = $clog2(WIDTH);

`ifdef TDM_PARITY_EN
  typedef enum logic [1:0] {HUNT, RECV, PAR} state_t;
`else
  typedef enum logic {HUNT, RECV} state_t;
`endif

  state_t          state;
  logic [BW-1:0]   bit_cnt;
  logic [CW-1:0]   ch_cnt;
  logic [N-1:0]    sr;
  logic [N-1:0]    sr_wr;
  logic [IW-1:0]   wr_idx;
  logic [N-1:0]    ch_data_q;
  logic            frame_valid_q;
  logic            sync_err_q;
  logic            frame_start;
  logic            last_bit;
  logic            bit_wrap;

  // Channel k occupies [k*WIDTH +: WIDTH]; bits arrive MSB first, so each bit lands directly in its slot.
  assign wr_idx      = IW'(ch_cnt) * IW'(WIDTH) + IW'(WIDTH - 1) - IW'(bit_cnt);
  assign bit_wrap    = (bit_cnt == BW'(WIDTH - 1));
  assign last_bit    = bit_wrap && (ch_cnt == CW'(CHANNELS - 1));
  // Counters sit at 0/0 in RECV only right after a completed frame, where sync is required.
  assign frame_start = (bit_cnt == '0) && (ch_cnt == '0);

  // Shift register with the current bit merged in, so a completing frame can load it in one edge.
  always_comb begin
    sr_wr         = sr;
    sr_wr[wr_idx] = bus.din;
  end

`ifdef TDM_PARITY_EN
  logic parity_err_q;
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.ch_data     = ch_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;

  // Alignment FSM, counters, deserialiser and registered output pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= HUNT;
      bit_cnt       <= '0;
      ch_cnt        <= '0;
      sr            <= '0;
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
`ifdef TDM_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
`ifdef TDM_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
      if (bus.en) begin
        case (state)
          HUNT: begin
            if (bus.sync) begin
              sr[WIDTH-1] <= bus.din;
              bit_cnt     <= BW'(1);
              ch_cnt      <= '0;
              state       <= RECV;
            end
          end
          RECV: begin
            if (frame_start) begin
              if (bus.sync) begin
                sr[WIDTH-1] <= bus.din;
                bit_cnt     <= BW'(1);
              end else begin
                sync_err_q <= 1'b1;
                state      <= HUNT;
              end
            end else if (bus.sync) begin
              // Early sync: drop the partial frame and restart on this bit.
              sync_err_q  <= 1'b1;
              sr[WIDTH-1] <= bus.din;
              bit_cnt     <= BW'(1);
              ch_cnt      <= '0;
            end else begin
              sr <= sr_wr;
              if (last_bit) begin
                bit_cnt <= '0;
                ch_cnt  <= '0;
`ifdef TDM_PARITY_EN
                state   <= PAR;
`else
                ch_data_q     <= sr_wr;
                frame_valid_q <= 1'b1;
`endif
              end else if (bit_wrap) begin
                bit_cnt <= '0;
                ch_cnt  <= ch_cnt + CW'(1);
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end
`ifdef TDM_PARITY_EN
          PAR: begin
            state <= RECV;
            if (bus.sync) begin
              // The parity slot is never a frame start, so sync here is an early sync.
              sync_err_q  <= 1'b1;
              sr[WIDTH-1] <= bus.din;
              bit_cnt     <= BW'(1);
              ch_cnt      <= '0;
            end else if (bus.din == ^sr) begin
              ch_data_q     <= sr;
              frame_valid_q <= 1'b1;
            end else begin
              parity_err_q <= 1'b1;
            end
          end
`endif
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - directed table-driven bench for tdm_demux
module tb_tdm_demux;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int N  = CH * W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tdm_demux_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int fv_cnt, se_cnt, pe_cnt;
  int pe_tot   = 0;
  int both_tot = 0;
  logic        se_first, fv_last;
  logic [N-1:0] cd_first;

  typedef struct {
    logic [N-1:0] data;
    int           gap;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.frame_valid) fv_cnt++;
    if (bus.sync_err) se_cnt++;
    if (bus.parity_err) begin
      pe_cnt++;
      pe_tot++;
    end
    if (bus.frame_valid && bus.sync_err) both_tot++;
  endtask

  task automatic send_bit(input logic d, input logic s, input int gap, output logic fv, output logic se);
    bus.en   = 1'b1;
    bus.din  = d;
    bus.sync = s;
    tick();
    fv = bus.frame_valid;
    se = bus.sync_err;
    for (int g = 0; g < gap; g++) begin
      bus.en   = 1'b0;
      bus.din  = 1'($urandom);
      bus.sync = 1'($urandom);
      tick();
    end
  endtask

  task automatic send_frame(input logic [N-1:0] data, input int gap, input int nbits,
                            input logic use_sync, input logic bad_par);
    logic f, s;
    int idx;
    fv_cnt = 0;
    se_cnt = 0;
    pe_cnt = 0;
    for (int i = 0; i < nbits; i++) begin
      idx = (i / W) * W + (W - 1 - (i % W));
      send_bit(data[idx], use_sync && (i == 0), gap, f, s);
      if (i == 0) begin
        se_first = s;
        cd_first = bus.ch_data;
      end
      fv_last = f;
    end
`ifdef TDM_PARITY_EN
    if (nbits == N) begin
      send_bit((^data) ^ bad_par, 1'b0, gap, f, s);
      fv_last = f;
    end
`else
    if (bad_par) fv_last = 1'b0;
`endif
  endtask

  initial begin
    logic f, s;
    vecs[0] = '{32'h01FF3CA5, 0};
    vecs[1] = '{32'h01FF3CA5, 1};
    vecs[2] = '{32'h00000000, 0};
    vecs[3] = '{32'hFFFFFFFF, 2};
    vecs[4] = '{32'h80000001, 0};
    vecs[5] = '{32'h0F0F5A5A, 1};

    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.din  = 1'b0;
    bus.sync = 1'b0;
    tick();
    tick();
    check("reset_ch_data", bus.ch_data, '0);
    check("reset_frame_valid", N'(bus.frame_valid), '0);
    check("reset_sync_err", N'(bus.sync_err), '0);
    check("reset_parity_err", N'(bus.parity_err), '0);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].gap, N, 1'b1, 1'b0);
      check($sformatf("vec%0d_ch_data", v), bus.ch_data, vecs[v].data);
      check($sformatf("vec%0d_fv_count", v), N'(fv_cnt), N'(1));
      check($sformatf("vec%0d_fv_on_last_bit", v), N'(fv_last), N'(1));
      check($sformatf("vec%0d_sync_err_count", v), N'(se_cnt), '0);
    end

    send_frame(32'h0BADF00D, 0, 12, 1'b1, 1'b0);
    check("early_partial_no_fv", N'(fv_cnt), '0);
    send_frame(32'h11223344, 0, N, 1'b1, 1'b0);
    check("early_sync_err", N'(se_first), N'(1));
    check("early_ch_data_held", cd_first, 32'h0F0F5A5A);
    check("early_ch_data", bus.ch_data, 32'h11223344);
    check("early_fv_count", N'(fv_cnt), N'(1));
    check("early_se_count", N'(se_cnt), N'(1));

    send_bit(1'b1, 1'b0, 0, f, s);
    check("missing_sync_err", N'(s), N'(1));
    check("missing_sync_no_fv", N'(f), '0);
    send_frame(32'hCAFEBABE, 0, N, 1'b0, 1'b0);
    check("hunt_no_fv", N'(fv_cnt), '0);
    check("hunt_no_se", N'(se_cnt), '0);
    check("hunt_ch_data_held", bus.ch_data, 32'h11223344);
    send_frame(32'hCAFEBABE, 0, N, 1'b1, 1'b0);
    check("relock_ch_data", bus.ch_data, 32'hCAFEBABE);
    check("relock_fv_count", N'(fv_cnt), N'(1));

    send_frame(32'h12345678, 0, 20, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    check("midrst_ch_data", bus.ch_data, '0);
    check("midrst_frame_valid", N'(bus.frame_valid), '0);
    check("midrst_sync_err", N'(bus.sync_err), '0);
    check("midrst_parity_err", N'(bus.parity_err), '0);
    rst_n = 1'b1;
    send_frame(32'hDEADBEEF, 0, N, 1'b1, 1'b0);
    check("postrst_ch_data", bus.ch_data, 32'hDEADBEEF);
    check("postrst_fv_count", N'(fv_cnt), N'(1));
    check("postrst_no_se", N'(se_first), '0);

`ifdef TDM_PARITY_EN
    send_frame(32'h01FF3CA5, 0, N, 1'b1, 1'b0);
    check("par_good_fv", N'(fv_cnt), N'(1));
    check("par_good_pe", N'(pe_cnt), '0);
    check("par_good_ch_data", bus.ch_data, 32'h01FF3CA5);
    send_frame(32'h5555AAAA, 0, N, 1'b1, 1'b1);
    check("par_bad_pe", N'(pe_cnt), N'(1));
    check("par_bad_no_fv", N'(fv_cnt), '0);
    check("par_bad_ch_data_held", bus.ch_data, 32'h01FF3CA5);
    send_frame(32'h13579BDF, 0, N, 1'b1, 1'b0);
    check("par_recover_fv", N'(fv_cnt), N'(1));
    check("par_recover_se", N'(se_cnt), '0);
    check("par_recover_ch_data", bus.ch_data, 32'h13579BDF);
`else
    check("no_parity_err_ever", N'(pe_tot), '0);
`endif

    check("fv_and_se_never_together", N'(both_tot), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
